// File: rtl/pc_branch_redirect_pkg.sv
// ----------------------------------------------------------------------------
// pc_stage_pkg
//  Shared definitions for the PC / branch-redirect stage.
//  - state_t            : FSM encoding (RUN = normal fetch, FLUSH = squashing)
//  - PC_STEP            : sequential fetch increment
//  - FLUSH_CNT_W        : width of the flush cycle counter (covers 1..7)
//  - JUMP_FLUSH_CYCLES  : flush length after a jump (IF/ID only)
// ----------------------------------------------------------------------------
package pc_stage_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [31:0] PC_STEP           = 32'd4;
    localparam int          FLUSH_CNT_W       = 3;
    localparam int          JUMP_FLUSH_CYCLES = 1;

endpackage

// File: rtl/pc_branch_redirect_if.sv
// ----------------------------------------------------------------------------
// pc_branch_redirect_if
//  Bundles the control/datapath signals between the pipeline and the PC stage.
//  master : pipeline side (hazard unit, branch resolution, fetch consumer)
//  slave  : the PC stage itself
//  Signals:
//   stall_i, branch_i, branch_base_i, branch_offset_i   -> into the PC stage
//   pc_o, pc_plus4_o, flush_o, redirect_o                <- from the PC stage
//  Optional (macro PC_JUMP_EN): jump_i, jump_index_i     -> into the PC stage
// ----------------------------------------------------------------------------
interface pc_branch_redirect_if;

    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_base_i;
    logic [31:0] branch_offset_i;
`ifdef PC_JUMP_EN
    logic        jump_i;
    logic [25:0] jump_index_i;
`endif
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        flush_o;
    logic        redirect_o;

    modport master (
        output stall_i, branch_i, branch_base_i, branch_offset_i,
`ifdef PC_JUMP_EN
        output jump_i, jump_index_i,
`endif
        input  pc_o, pc_plus4_o, flush_o, redirect_o
    );

    modport slave (
        input  stall_i, branch_i, branch_base_i, branch_offset_i,
`ifdef PC_JUMP_EN
        input  jump_i, jump_index_i,
`endif
        output pc_o, pc_plus4_o, flush_o, redirect_o
    );

endinterface

// File: rtl/pc_branch_redirect_target_adder.sv
// ----------------------------------------------------------------------------
// pc_target_adder
//  Combinational branch target: base + word-aligned offset, modulo 2^32.
//  Ports:
//   base    in  32  PC+4 of the branch instruction
//   offset  in  32  shifted immediate; low two bits are cleared before the add
//   target  out 32  branch target (carry out discarded)
// ----------------------------------------------------------------------------
module pc_target_adder (
    input  logic [31:0] base,
    input  logic [31:0] offset,
    output logic [31:0] target
);

    // Low bits are masked so a malformed offset can never produce an
    // unaligned fetch address.
    assign target = base + (offset & ~32'd3);

endmodule

// File: rtl/pc_branch_redirect.sv
// ----------------------------------------------------------------------------
// pc_branch_redirect
//  Program-counter stage: holds the fetch PC, steps it by 4, redirects it on a
//  taken branch and drives a timed flush of the younger pipeline registers.
//  Parameters:
//   RESET_PC      PC loaded on reset
//   FLUSH_CYCLES  cycles flush_o stays high after a branch redirect (1..7)
//  Ports:
//   clk_i   in  rising-edge clock
//   rst_i   in  asynchronous reset, active-low
//   bus     slave side of pc_branch_redirect_if (see interface header)
//  Optional feature macro PC_JUMP_EN: J-type jump redirect with 1-cycle flush.
// ----------------------------------------------------------------------------
module pc_branch_redirect
    import pc_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pc_branch_redirect_if.slave   bus
);

    state_t                 state_q, state_n;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_n;
    logic [31:0]            pc_q, pc_n;
    logic                   flush_q, flush_n;
    logic                   redirect_q, redirect_n;
    logic [31:0]            target;
    logic [31:0]            pc_seq;

    pc_target_adder u_target_adder (
        .base   (bus.branch_base_i),
        .offset (bus.branch_offset_i),
        .target (target)
    );

    assign pc_seq = pc_q + PC_STEP;

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        pc_n       = pc_q;
        flush_n    = flush_q;
        redirect_n = 1'b0;

        unique case (state_q)
            RUN: begin
                // Branch is checked first: it wins over a same-cycle stall
                // (and over a jump, since the branch is the older instruction).
                if (bus.branch_i) begin
                    pc_n       = target;
                    state_n    = FLUSH;
                    cnt_n      = FLUSH_CNT_W'(FLUSH_CYCLES);
                    redirect_n = 1'b1;
                    flush_n    = 1'b1;
                end
`ifdef PC_JUMP_EN
                else if (bus.jump_i) begin
                    pc_n       = {pc_q[31:28], bus.jump_index_i, 2'b00};
                    state_n    = FLUSH;
                    cnt_n      = FLUSH_CNT_W'(JUMP_FLUSH_CYCLES);
                    redirect_n = 1'b1;
                    flush_n    = 1'b1;
                end
`endif
                else if (bus.stall_i) begin
                    flush_n = 1'b0;
                end else begin
                    pc_n    = pc_seq;
                    flush_n = 1'b0;
                end
            end
            FLUSH: begin
                // Requests seen here belong to squashed instructions.
                pc_n  = pc_seq;
                cnt_n = cnt_q - 1'b1;
                if (cnt_q == FLUSH_CNT_W'(1)) begin
                    flush_n = 1'b0;
                    state_n = RUN;
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            pc_q       <= pc_n;
            flush_q    <= flush_n;
            redirect_q <= redirect_n;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_plus4_o = pc_seq;
    assign bus.flush_o    = flush_q;
    assign bus.redirect_o = redirect_q;

endmodule

// File: tb/tb_pc_branch_redirect.sv
// ----------------------------------------------------------------------------
// tb_pc_branch_redirect
//  Self-checking bench for pc_branch_redirect: a directed vector table, an
//  asynchronous-reset sequence, an optional jump sequence (PC_JUMP_EN) and a
//  randomized run against a behavioural reference model.
// ----------------------------------------------------------------------------
module tb_pc_branch_redirect;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    pc_branch_redirect_if bus ();

    pc_branch_redirect #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        stall;
        logic        branch;
        logic [31:0] base;
        logic [31:0] offset;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic        exp_redir;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic branch,
                         input logic [31:0] base, input logic [31:0] offset);
        bus.stall_i         = stall;
        bus.branch_i        = branch;
        bus.branch_base_i   = base;
        bus.branch_offset_i = offset;
`ifdef PC_JUMP_EN
        bus.jump_i          = 1'b0;
        bus.jump_index_i    = '0;
`endif
    endtask

    task automatic step_chk(input string tag, input logic [31:0] pc,
                            input logic flush, input logic redir);
        @(posedge clk_i);
        @(negedge clk_i);
        chk({tag, ".pc"},       bus.pc_o,       pc);
        chk({tag, ".pc_plus4"}, bus.pc_plus4_o, pc + 32'd4);
        chk({tag, ".flush"},    32'(bus.flush_o),    32'(flush));
        chk({tag, ".redirect"}, 32'(bus.redirect_o), 32'(redir));
    endtask

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] ba,
                                input logic [31:0] of, input logic [31:0] pc,
                                input logic fl, input logic rd);
        vec_t v;
        v.stall = s; v.branch = b; v.base = ba; v.offset = of;
        v.exp_pc = pc; v.exp_flush = fl; v.exp_redir = rd;
        return v;
    endfunction

    // Reference model: redirect opens a squash window of FLUSH_CYCLES cycles
    // during which everything steps by 4; outside it branch > stall > step.
    logic [31:0] m_pc;
    int          m_flush_left;
    logic        m_redir;

    task automatic model_edge(input logic stall, input logic branch,
                              input logic [31:0] base, input logic [31:0] offset);
        longint sum;
        m_redir = 1'b0;
        if (m_flush_left > 0) begin
            m_pc = m_pc + 32'd4;
            m_flush_left--;
        end else if (branch) begin
            sum = longint'(base) + longint'(offset - (offset % 4));
            m_pc = sum[31:0];
            m_flush_left = FLUSH_CYCLES;
            m_redir = 1'b1;
        end else if (!stall) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        logic [31:0] start_pc;

        drive(1'b0, 1'b0, '0, '0);

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        chk("reset.pc",       bus.pc_o, RESET_PC);
        chk("reset.flush",    32'(bus.flush_o), 32'd0);
        chk("reset.redirect", 32'(bus.redirect_o), 32'd0);
        rst_i = 1'b1;

        // Directed table
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_0004, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_0008, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_000C, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_0010, 0, 0));
        vecs.push_back(mk(0, 1, 32'h14,        32'h20,        32'h0000_0034, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_0038, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_003C, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_0040, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,         32'h0,         32'h0000_0040, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,         32'h0,         32'h0000_0040, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,         32'h0,         32'h0000_0040, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_0044, 0, 0));
        vecs.push_back(mk(1, 1, 32'h100,       32'hFFFF_FFF0, 32'h0000_00F0, 1, 1));
        vecs.push_back(mk(0, 1, 32'h200,       32'h40,        32'h0000_00F4, 1, 0));
        vecs.push_back(mk(1, 1, 32'h300,       32'h40,        32'h0000_00F8, 0, 0));
        vecs.push_back(mk(0, 1, 32'h1000,      32'h13,        32'h0000_1010, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_1014, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_1018, 0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFF8, 32'h8,         32'h0000_0000, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_0004, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_0008, 0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFF0, 32'hC,         32'hFFFF_FFFC, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_0000, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,         32'h0000_0004, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].branch, vecs[i].base, vecs[i].offset);
            step_chk($sformatf("vec%0d", i), vecs[i].exp_pc,
                     vecs[i].exp_flush, vecs[i].exp_redir);
        end

        // Asynchronous reset in the middle of a flush window
        drive(1'b0, 1'b1, 32'h500, 32'h10);
        step_chk("arst.branch", 32'h0000_0510, 1'b1, 1'b1);
        drive(1'b0, 1'b0, '0, '0);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst.pc",       bus.pc_o, RESET_PC);
        chk("arst.flush",    32'(bus.flush_o), 32'd0);
        chk("arst.redirect", 32'(bus.redirect_o), 32'd0);
        @(negedge clk_i);
        chk("arst.hold_pc", bus.pc_o, RESET_PC);
        rst_i = 1'b1;
        step_chk("arst.rel1", RESET_PC + 32'd4, 1'b0, 1'b0);
        step_chk("arst.rel2", RESET_PC + 32'd8, 1'b0, 1'b0);
        start_pc = RESET_PC + 32'd8;

`ifdef PC_JUMP_EN
        drive(1'b0, 1'b1, 32'h1000_0000, 32'h0);
        step_chk("jmp.setup0", 32'h1000_0000, 1'b1, 1'b1);
        drive(1'b0, 1'b0, '0, '0);
        step_chk("jmp.setup1", 32'h1000_0004, 1'b1, 1'b0);
        step_chk("jmp.setup2", 32'h1000_0008, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, '0);
        bus.jump_i       = 1'b1;
        bus.jump_index_i = 26'h00_0040;
        step_chk("jmp.take", 32'h1000_0100, 1'b1, 1'b1);
        drive(1'b0, 1'b0, '0, '0);
        bus.jump_i       = 1'b1;
        bus.jump_index_i = 26'h00_0080;
        step_chk("jmp.ignored", 32'h1000_0104, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h200, 32'h20);
        bus.jump_i       = 1'b1;
        bus.jump_index_i = 26'h00_0040;
        step_chk("jmp.both", 32'h0000_0220, 1'b1, 1'b1);
        drive(1'b0, 1'b0, '0, '0);
        step_chk("jmp.both1", 32'h0000_0224, 1'b1, 1'b0);
        step_chk("jmp.both2", 32'h0000_0228, 1'b0, 1'b0);
        start_pc = 32'h0000_0228;
`endif

        // Randomized run against the reference model
        m_pc = start_pc;
        m_flush_left = 0;
        m_redir = 1'b0;
        for (int k = 0; k < 400; k++) begin
            logic        s, b;
            logic [31:0] ba, of;
            s  = ($urandom_range(0, 2) == 0);
            b  = ($urandom_range(0, 4) == 0);
            ba = $urandom;
            of = $urandom;
            drive(s, b, ba, of);
            model_edge(s, b, ba, of);
            step_chk($sformatf("rnd%0d", k), m_pc, (m_flush_left > 0), m_redir);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
